// File: rtl/dmem_arbiter_if.sv
// Handshake bundle between dmem_arbiter, its two requesters (core LSU on port 0,
// debug loader on port 1) and the single-port data memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req_0;
  logic              i_req_1;
  logic              i_wren_0;
  logic              i_wren_1;
  logic [ADDR_W-1:0] i_addr_0;
  logic [ADDR_W-1:0] i_addr_1;
  logic [DATA_W-1:0] i_wdata_0;
  logic [DATA_W-1:0] i_wdata_1;
  logic              o_ack_0;
  logic              o_ack_1;
  logic [DATA_W-1:0] o_rdata_0;
  logic [DATA_W-1:0] o_rdata_1;
  logic              o_stall_core;
  logic              o_busy;
  logic              o_mem_en;
  logic              o_mem_wren;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_req_0, i_req_1, i_wren_0, i_wren_1, i_addr_0, i_addr_1,
           i_wdata_0, i_wdata_1, i_mem_rdata,
    output o_ack_0, o_ack_1, o_rdata_0, o_rdata_1, o_stall_core, o_busy,
           o_mem_en, o_mem_wren, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req_0, i_req_1, i_wren_0, i_wren_1, i_addr_0, i_addr_1,
           i_wdata_0, i_wdata_1, i_mem_rdata,
    input  o_ack_0, o_ack_1, o_rdata_0, o_rdata_1, o_stall_core, o_busy,
           o_mem_en, o_mem_wren, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core LSU
// (port 0) and the debug/loader port (port 1); one access in flight at a time.
module dmem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input logic           i_clk,
  input logic           i_rst,
  dmem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int              CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [1:0]        state;
  logic              last_grant;
  logic              win;
  logic              pick;
  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_0_q;
  logic [DATA_W-1:0] rdata_1_q;

  // On a tie the port that did not win last time goes; a lone requester always wins.
  // NOTE: every path assigns pick, so no latch can be inferred here.
  always_comb begin
    if (bus.i_req_0 && bus.i_req_1) pick = ~last_grant;
    else                            pick = bus.i_req_1;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: datapath registers are reset as well; mem bus and rdata must read 0 out of reset.
      state      <= IDLE;
      last_grant <= 1'b1;
      win        <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      rdata_0_q  <= '0;
      rdata_1_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req_0 || bus.i_req_1) begin
            win        <= pick;
            last_grant <= pick;
            wren_q     <= pick ? bus.i_wren_1  : bus.i_wren_0;
            addr_q     <= pick ? bus.i_addr_1  : bus.i_addr_0;
            wdata_q    <= pick ? bus.i_wdata_1 : bus.i_wdata_0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (wren_q) begin
            state <= IDLE;
          end else begin
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            if (win) rdata_1_q <= bus.i_mem_rdata;
            else     rdata_0_q <= bus.i_mem_rdata;
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_LAST;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic in_issue;
  logic in_resp;
  logic done;

  assign in_issue = (state == ISSUE);
  assign in_resp  = (state == RESP);
  // Writes complete in the strobe cycle; reads complete in RESP.
  assign done     = (in_issue && wren_q) || in_resp;

  assign bus.o_ack_0      = done && !win;
  assign bus.o_ack_1      = done && win;
  assign bus.o_rdata_0    = rdata_0_q;
  assign bus.o_rdata_1    = rdata_1_q;
  assign bus.o_stall_core = bus.i_req_0 && !bus.o_ack_0;
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_mem_en     = in_issue;
  assign bus.o_mem_wren   = in_issue && wren_q;
  assign bus.o_mem_addr   = addr_q;
  assign bus.o_mem_wdata  = wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 uses MEM_LAT=1, instance 1 MEM_LAT=3; a
// timestamp-level transaction model checks every output on every falling edge.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req   [2][2];
  logic          wren  [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          ack   [2][2];
  logic [DW-1:0] rdata [2][2];
  logic          stall    [2];
  logic          busy     [2];
  logic          mem_en   [2];
  logic          mem_wren [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata[2];

  int n_checks = 0;
  int n_fail   = 0;
  int grant_order[$];
  int lat_of [2] = '{1, 3};

  // Contents of a memory word that has never been written.
  function automatic logic [DW-1:0] init_val(input logic [5:0] idx);
    return 32'h5EED_0000 + 32'(idx);
  endfunction

  generate
    for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int LAT = (g == 0) ? 1 : 3;

      dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

      dmem_arbiter #(.MEM_LAT(LAT), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
      );

      assign bus.i_req_0   = req[g][0];
      assign bus.i_req_1   = req[g][1];
      assign bus.i_wren_0  = wren[g][0];
      assign bus.i_wren_1  = wren[g][1];
      assign bus.i_addr_0  = addr[g][0];
      assign bus.i_addr_1  = addr[g][1];
      assign bus.i_wdata_0 = wdata[g][0];
      assign bus.i_wdata_1 = wdata[g][1];
      assign ack[g][0]     = bus.o_ack_0;
      assign ack[g][1]     = bus.o_ack_1;
      assign rdata[g][0]   = bus.o_rdata_0;
      assign rdata[g][1]   = bus.o_rdata_1;
      assign stall[g]      = bus.o_stall_core;
      assign busy[g]       = bus.o_busy;
      assign mem_en[g]     = bus.o_mem_en;
      assign mem_wren[g]   = bus.o_mem_wren;
      assign mem_addr[g]   = bus.o_mem_addr;
      assign mem_wdata[g]  = bus.o_mem_wdata;

      // Single-port memory: read data appears LAT cycles after the command, noise otherwise.
      logic [DW-1:0] mem     [64];
      bit            written [64];
      logic [DW-1:0] pipe    [LAT];
      logic [5:0]    idx;
      assign idx = bus.o_mem_addr[7:2];

      always @(posedge clk) begin
        if (bus.o_mem_en && bus.o_mem_wren) begin
          mem[idx]     <= bus.o_mem_wdata;
          written[idx] <= 1'b1;
        end
        pipe[0] <= (bus.o_mem_en && !bus.o_mem_wren) ?
                   (written[idx] ? mem[idx] : init_val(idx)) : DW'($urandom);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign bus.i_mem_rdata = pipe[LAT-1];
    end
  endgenerate

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            m_act   [2];
  int            m_issue [2];
  int            m_ack   [2];
  bit            m_win   [2];
  bit            m_wren  [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] m_val   [2];
  bit            m_last  [2];
  logic [DW-1:0] m_rd    [2][2];
  logic [DW-1:0] mmem    [2][64];
  bit            mwr     [2][64];

  initial begin : compare
    int   now;
    logic e_ack0, e_ack1, e_busy, e_en;
    bit   p;
    logic [5:0] ix;
    now = 0;
    forever begin
      @(negedge clk);
      now++;
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          m_act[g]   = 1'b0;
          m_last[g]  = 1'b1;
          m_rd[g][0] = '0;
          m_rd[g][1] = '0;
          e_en = 1'b0; e_busy = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
        end else begin
          e_en   = m_act[g] && (now == m_issue[g]);
          e_busy = m_act[g] && (now >= m_issue[g]);
          e_ack0 = m_act[g] && (now == m_ack[g]) && !m_win[g];
          e_ack1 = m_act[g] && (now == m_ack[g]) &&  m_win[g];
          if (m_act[g] && now == m_ack[g] && !m_wren[g]) m_rd[g][m_win[g]] = m_val[g];
        end
        check($sformatf("ack0[%0d]@%0d", g, now), ack[g][0], e_ack0);
        check($sformatf("ack1[%0d]@%0d", g, now), ack[g][1], e_ack1);
        check($sformatf("busy[%0d]@%0d", g, now), busy[g], e_busy);
        check($sformatf("mem_en[%0d]@%0d", g, now), mem_en[g], e_en);
        check($sformatf("stall[%0d]@%0d", g, now), stall[g], req[g][0] && !e_ack0);
        check($sformatf("rdata0[%0d]@%0d", g, now), rdata[g][0], m_rd[g][0]);
        check($sformatf("rdata1[%0d]@%0d", g, now), rdata[g][1], m_rd[g][1]);
        if (e_en) begin
          check($sformatf("mem_wren[%0d]@%0d", g, now), mem_wren[g], m_wren[g]);
          check($sformatf("mem_addr[%0d]@%0d", g, now), mem_addr[g], m_addr[g]);
          if (m_wren[g]) check($sformatf("mem_wdata[%0d]@%0d", g, now), mem_wdata[g], m_wdata[g]);
        end else if (rst) begin
          check($sformatf("rst_mem_wren[%0d]@%0d", g, now), mem_wren[g], 1'b0);
          check($sformatf("rst_mem_addr[%0d]@%0d", g, now), mem_addr[g], '0);
          check($sformatf("rst_mem_wdata[%0d]@%0d", g, now), mem_wdata[g], '0);
        end
        if (!rst) begin
          if (m_act[g] && now == m_ack[g]) begin
            m_act[g] = 1'b0;
          end else if (!m_act[g] && (req[g][0] || req[g][1])) begin
            p = (req[g][0] && req[g][1]) ? !m_last[g] : req[g][1];
            m_last[g]  = p;
            m_win[g]   = p;
            m_wren[g]  = wren[g][p];
            m_addr[g]  = addr[g][p];
            m_wdata[g] = wdata[g][p];
            m_act[g]   = 1'b1;
            m_issue[g] = now + 1;
            m_ack[g]   = wren[g][p] ? now + 1 : now + 2 + lat_of[g];
            ix = m_addr[g][7:2];
            if (m_wren[g]) begin
              mmem[g][ix] = m_wdata[g];
              mwr[g][ix]  = 1'b1;
            end else begin
              m_val[g] = mwr[g][ix] ? mmem[g][ix] : init_val(ix);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Entered at posedge+1 of cycle 0; returns at posedge+1 of the cycle after the ack.
  task automatic do_req(input int g, input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat);
    int c;
    bit got;
    c = 0;
    got = 1'b0;
    lat = -1;
    req[g][p] = 1'b1; wren[g][p] = w; addr[g][p] = a; wdata[g][p] = d;
    while (!got && c < 60) begin
      @(negedge clk);
      if (ack[g][p] === 1'b1) begin
        got = 1'b1;
        lat = c;
        if (g == 0) grant_order.push_back(p);
      end
      @(posedge clk); #1;
      c++;
    end
    req[g][p] = 1'b0;
    check($sformatf("ack_seen[%0d][%0d]", g, p), got, 1'b1);
  endtask

  task automatic rand_traffic(input int g, input int p, input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      do_req(g, p, 1'($urandom_range(0, 1)), {24'h0, 6'($urandom), 2'b00}, $urandom, lat);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin : main
    int lat_a, lat_b;
    for (int g = 0; g < 2; g++)
      for (int p = 0; p < 2; p++) begin
        req[g][p] = 1'b0; wren[g][p] = 1'b0; addr[g][p] = '0; wdata[g][p] = '0;
      end
    apply_reset();

    // Single core write, then a loader write feeding a core read (MEM_LAT=1).
    do_req(0, 0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat_a);
    check("core_wr_lat", lat_a, 1);
    do_req(0, 1, 1'b1, 32'h20, 32'h1234_5678, lat_a);
    check("dbg_wr_lat", lat_a, 1);
    do_req(0, 0, 1'b0, 32'h20, '0, lat_a);
    check("core_rd_lat", lat_a, 3);
    check("core_rd_data", rdata[0][0], 32'h1234_5678);
    repeat (3) begin @(posedge clk); #1; end
    check("core_rd_held", rdata[0][0], 32'h1234_5678);

    // Both ports writing back to back from reset must alternate, core first.
    apply_reset();
    grant_order.delete();
    fork
      begin do_req(0, 0, 1'b1, 32'h80, 32'h1, lat_a); do_req(0, 0, 1'b1, 32'h84, 32'h2, lat_a); end
      begin do_req(0, 1, 1'b1, 32'h88, 32'h3, lat_b); do_req(0, 1, 1'b1, 32'h8C, 32'h4, lat_b); end
    join
    check("order_len", grant_order.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("order[%0d]", i), (grant_order.size() > i) ? grant_order[i] : -1, i % 2);

    // MEM_LAT=3: loader read at cycle 0, core write raised at cycle 2.
    do_req(1, 0, 1'b1, 32'h40, 32'hCAFE_F00D, lat_a);
    check("l3_wr_lat", lat_a, 1);
    fork
      begin do_req(1, 1, 1'b0, 32'h40, '0, lat_a); end
      begin
        repeat (2) begin @(posedge clk); #1; end
        do_req(1, 0, 1'b1, 32'h44, 32'h0BAD_F00D, lat_b);
      end
    join
    check("l3_rd_lat", lat_a, 5);
    check("l3_rd_data", rdata[1][1], 32'hCAFE_F00D);
    check("l3_core_lat", lat_b, 5);

    // Reset during WAIT of a loader read: abandoned, no ack, outputs clear at once.
    req[1][1] = 1'b1; wren[1][1] = 1'b0; addr[1][1] = 32'h48;
    repeat (2) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_now_ack0[%0d]", g), ack[g][0], 1'b0);
      check($sformatf("rst_now_ack1[%0d]", g), ack[g][1], 1'b0);
      check($sformatf("rst_now_busy[%0d]", g), busy[g], 1'b0);
      check($sformatf("rst_now_mem_en[%0d]", g), mem_en[g], 1'b0);
      check($sformatf("rst_now_mem_addr[%0d]", g), mem_addr[g], '0);
      check($sformatf("rst_now_rdata1[%0d]", g), rdata[g][1], '0);
    end
    req[1][1] = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    do_req(1, 0, 1'b1, 32'h50, 32'h5555_AAAA, lat_a);
    check("post_rst_lat", lat_a, 1);
    check("post_rst_rdata1", rdata[1][1], '0);

    // Random traffic on all four requesters.
    fork
      rand_traffic(0, 0, 40);
      rand_traffic(0, 1, 40);
      rand_traffic(1, 0, 40);
      rand_traffic(1, 1, 40);
    join
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port data memory between the core load/store unit (port 0) and the debug/program-loader port (port 1).
Each requester uses a request-hold / acknowledge handshake.
The block sequences every access through a small FSM and grants ports round-robin.
It drives a stall to the single-cycle core while a core access is pending.

## Interface
- MEM_LAT, default 1: memory read latency in cycles, legal range ≥1.
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high.
- i_req_0 / i_req_1  in  1  access request, held until the matching ack.
- i_wren_0 / i_wren_1  in  1  1 = write, 0 = read; stable while req is high.
- i_addr_0 / i_addr_1  in  ADDR_W  access address; stable while req is high.
- i_wdata_0 / i_wdata_1  in  DATA_W  write data; stable while req is high.
- o_ack_0 / o_ack_1  out  1  one-cycle completion pulse.
- o_rdata_0 / o_rdata_1  out  DATA_W  read data; valid in the ack cycle of a read, held until that port's next read completes.
- o_stall_core  out  1  equals i_req_0 & ~o_ack_0 (combinational).
- o_busy  out  1  high when the FSM is not IDLE.
- o_mem_en  out  1  memory command strobe.
- o_mem_wren  out  1  memory write enable, qualified by o_mem_en.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  DATA_W  memory write data.
- i_mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read command.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any req is high, pick a winner and latch its wren/addr/wdata plus the winner id. Go to ISSUE.
  - With no req, stay in IDLE.
- **Arbitration:**
  - A single requester always wins.
  - When both request, the port not in last_grant wins.
  - last_grant updates when the winner is latched. Its reset value is 1, so the core wins the first tie.
- **ISSUE:**
  - o_mem_en=1 and the mem bus carries the latched command.
  - Write: o_ack_<winner>=1 in this cycle, then go to IDLE.
  - Read: load the wait counter with MEM_LAT, then go to WAIT.
- **WAIT:**
  - The counter decrements each cycle.
  - When it reaches 1, capture i_mem_rdata into o_rdata_<winner> at that edge, then go to RESP.
- **RESP:** o_ack_<winner>=1 for one cycle, then go to IDLE.
- **Requester rule:** a requester samples ack in the ack cycle and must drop or replace its request at the edge ending that cycle. A req still high in the following IDLE cycle is treated as a new request.
- **Ignored inputs:** the non-winning port's inputs are ignored until the arbiter is back in IDLE; that port's req stays pending.
- **Counter width:** clog2(MEM_LAT+1). Counter and address logic never wrap, since address passes through unmodified.
- **Reset, mid-operation or otherwise:**
  - State goes to IDLE and last_grant to 1.
  - All o_ack, o_mem_en, o_mem_wren, o_busy go to 0. o_mem_addr, o_mem_wdata, both o_rdata go to 0.
  - An in-flight access is abandoned with no ack. A write already strobed in ISSUE may have committed.

## Timing
- Request first seen high in IDLE at cycle 0.
- Write: o_mem_en and ack in cycle 1, so write latency is 1 cycle. The earliest next grant is IDLE at cycle 2, with ISSUE at cycle 3.
- Read: ISSUE at cycle 1, WAIT for cycles 2..1+MEM_LAT, RESP/ack at cycle 2+MEM_LAT. With MEM_LAT=1, ack lands at cycle 3.
- Maximum throughput:
  - writes: one per 2 cycles;
  - reads: one per 3+MEM_LAT cycles.
- All outputs except o_stall_core are registered or decoded directly from state registers. There is no combinational path from i_req to the mem bus.
- o_stall_core is combinational from i_req_0, so the core stays stalled from cycle 0 through the cycle before ack.

## Test plan
- **Reset:** pulse i_rst asynchronously mid-cycle -> all outputs 0 immediately, o_busy=0.
- **Single core write:** core write addr 0x10, data 0xDEADBEEF -> cycle 1 has o_mem_en=1, o_mem_wren=1, addr 0x10, wdata 0xDEADBEEF, o_ack_0=1; o_stall_core high only in cycle 0.
- **Single core read, MEM_LAT=1:** core read addr 0x20, memory model returns 0x12345678 -> o_ack_0 at cycle 3, o_rdata_0=0x12345678 at cycle 3 and held afterwards.
- **Contention:** both ports request writes from reset and re-request immediately after each ack -> grant order 0,1,0,1; neither port is acked twice in a row.
- **Reset mid-read:** assert i_rst during WAIT of a port-1 read -> no o_ack_1, state IDLE, o_rdata_1=0; the next core request is granted normally.
- **Longer latency, MEM_LAT=3:** debug read addr 0x40, memory returns 0xCAFEF00D -> o_ack_1 at cycle 5 with that data; a core request raised at cycle 2 is granted in the IDLE cycle 6 and acked by cycle 7 for a write.
